// File: rtl/timer_pkg.sv
// Shared encodings and constants for the countdown timer mode controller.
package timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_EXPIRED = 3'd4
  } state_e;

  localparam logic [3:0] TEN        = 4'd10;
  localparam logic [3:0] SIX        = 4'd6;
  localparam logic [7:0] PRESET_RST = 8'h00;

endpackage

// File: rtl/bcd60_inc.sv
// Combinational mod-60 incrementer on packed BCD {tens,units}; 59 wraps to 00.
module bcd60_inc
  import timer_pkg::*;
(
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [3:0] unit_inc, tens_inc;
  logic       carry;

  assign unit_inc = d[3:0] + 4'd1;
  assign tens_inc = d[7:4] + 4'd1;
  assign carry    = (unit_inc == TEN);

  assign q[3:0] = carry ? 4'd0 : unit_inc;
  assign q[7:4] = carry ? ((tens_inc == SIX) ? 4'd0 : tens_inc) : d[7:4];

endmodule

// File: rtl/timer_ctrl.sv
// Mode controller for the countdown timer: preset entry, core enable/reset sequencing, alarm.
// Define TIMER_CTRL_AUTORELOAD_EN to restart the countdown automatically when the alarm ends.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ALARM_CYCLES = 16
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic       min_inc_i,
  input  logic       sec_inc_i,
  input  logic       time_out_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] ms_10_o,
  output logic       core_en_o,
  output logic       core_rst_o,
  output logic       alarm_o,
  output logic [2:0] state_o
);

  localparam int            AW       = $clog2(ALARM_CYCLES + 1);
  localparam logic [AW-1:0] ALARM_LD = AW'(ALARM_CYCLES);

  state_e        state, nxt;
  logic [AW-1:0] alarm_cnt;
  logic [7:0]    min_nxt, sec_nxt;
  logic          preset_zero;

  bcd60_inc u_min_inc (.d(min_o), .q(min_nxt));
  bcd60_inc u_sec_inc (.d(sec_o), .q(sec_nxt));

  assign preset_zero = (min_o == PRESET_RST) && (sec_o == PRESET_RST);
  assign ms_10_o     = PRESET_RST;
  assign state_o     = state;

  // clear beats start everywhere; time_out only matters while running
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (!clear_i && start_i && !preset_zero) nxt = S_LOAD;
      S_LOAD:    nxt = S_RUN;
      S_RUN:     if (time_out_i)   nxt = S_EXPIRED;
                 else if (clear_i) nxt = S_IDLE;
                 else if (start_i) nxt = S_PAUSE;
      S_PAUSE:   if (clear_i)      nxt = S_IDLE;
                 else if (start_i) nxt = S_RUN;
      S_EXPIRED: if (clear_i)      nxt = S_IDLE;
                 else if (start_i) nxt = S_LOAD;
`ifdef TIMER_CTRL_AUTORELOAD_EN
                 else if (alarm_cnt == AW'(1)) nxt = S_LOAD;
`endif
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      min_o      <= PRESET_RST;
      sec_o      <= PRESET_RST;
      core_rst_o <= 1'b1;
      core_en_o  <= 1'b0;
      alarm_o    <= 1'b0;
      alarm_cnt  <= '0;
    end else begin
      state      <= nxt;
      core_rst_o <= (nxt == S_IDLE) || (nxt == S_LOAD);
      core_en_o  <= (nxt == S_RUN);

      // alarm_o mirrors the counter's next value so it is high exactly ALARM_CYCLES cycles
      if (nxt == S_EXPIRED && state != S_EXPIRED) begin
        alarm_cnt <= ALARM_LD;
        alarm_o   <= 1'b1;
      end else if (nxt == S_EXPIRED) begin
        if (alarm_cnt != '0) alarm_cnt <= alarm_cnt - AW'(1);
        alarm_o <= (alarm_cnt > AW'(1));
      end else begin
        alarm_cnt <= '0;
        alarm_o   <= 1'b0;
      end

      if (state == S_IDLE) begin
        if (clear_i) begin
          min_o <= PRESET_RST;
          sec_o <= PRESET_RST;
        end else begin
          if (min_inc_i) min_o <= min_nxt;
          if (sec_inc_i) sec_o <= sec_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (ALARM_CYCLES = 16).
module tb_timer_ctrl;

  logic       clk_core = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0, clear_i = 1'b0, min_inc_i = 1'b0, sec_inc_i = 1'b0, time_out_i = 1'b0;
  logic [7:0] min_o, sec_o, ms_10_o;
  logic       core_en_o, core_rst_o, alarm_o;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  timer_ctrl #(.ALARM_CYCLES(16)) dut (
    .clk_core(clk_core), .rst(rst), .start_i(start_i), .clear_i(clear_i),
    .min_inc_i(min_inc_i), .sec_inc_i(sec_inc_i), .time_out_i(time_out_i),
    .min_o(min_o), .sec_o(sec_o), .ms_10_o(ms_10_o), .core_en_o(core_en_o),
    .core_rst_o(core_rst_o), .alarm_o(alarm_o), .state_o(state_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  // 0 start, 1 clear, 2 min_inc, 3 sec_inc, 4 time_out
  task automatic pulse(input int which);
    case (which)
      0: start_i    = 1'b1;
      1: clear_i    = 1'b1;
      2: min_inc_i  = 1'b1;
      3: sec_inc_i  = 1'b1;
      default: time_out_i = 1'b1;
    endcase
    tick;
    start_i = 1'b0; clear_i = 1'b0; min_inc_i = 1'b0; sec_inc_i = 1'b0; time_out_i = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_min"}, 32'(min_o), 32'h00);
    chk({tag, "_sec"}, 32'(sec_o), 32'h00);
    chk({tag, "_ms10"}, 32'(ms_10_o), 32'h00);
    chk({tag, "_crst"}, 32'(core_rst_o), 32'd1);
    chk({tag, "_en"}, 32'(core_en_o), 32'd0);
    chk({tag, "_alarm"}, 32'(alarm_o), 32'd0);
  endtask

  initial begin
    int high;
    tick; tick;
    chk_rst("rst");
    rst = 1'b1;

    // empty preset: start ignored
    pulse(0);
    chk("zero_start", 32'(state_o), 32'd0);
    tick;
    chk("zero_start2", 32'(state_o), 32'd0);

    // preset 01:03 then start
    repeat (3) pulse(3);
    pulse(2);
    chk("pre_sec", 32'(sec_o), 32'h03);
    chk("pre_min", 32'(min_o), 32'h01);
    pulse(0);
    chk("load_state", 32'(state_o), 32'd1);
    chk("load_crst", 32'(core_rst_o), 32'd1);
    chk("load_en", 32'(core_en_o), 32'd0);
    tick;
    chk("run_state", 32'(state_o), 32'd2);
    chk("run_en", 32'(core_en_o), 32'd1);
    chk("run_crst", 32'(core_rst_o), 32'd0);

    // pause / resume
    pulse(0);
    chk("pause_state", 32'(state_o), 32'd3);
    chk("pause_en", 32'(core_en_o), 32'd0);
    repeat (9) begin
      tick;
      chk("pause_en_hold", 32'(core_en_o), 32'd0);
      chk("pause_crst_hold", 32'(core_rst_o), 32'd0);
    end
    pulse(0);
    chk("resume_state", 32'(state_o), 32'd2);
    chk("resume_en", 32'(core_en_o), 32'd1);
    chk("resume_crst", 32'(core_rst_o), 32'd0);

    // time_out beats start
    time_out_i = 1'b1; start_i = 1'b1;
    tick;
    time_out_i = 1'b0; start_i = 1'b0;
    chk("exp_state", 32'(state_o), 32'd4);
    chk("exp_en", 32'(core_en_o), 32'd0);
    chk("exp_alarm", 32'(alarm_o), 32'd1);
    high = 1;
    repeat (15) begin
      tick;
      high += int'(alarm_o);
    end
    tick;
    chk("alarm_len", 32'(high), 32'd16);
    chk("alarm_off", 32'(alarm_o), 32'd0);
    chk("exp_min_hold", 32'(min_o), 32'h01);
    chk("exp_sec_hold", 32'(sec_o), 32'h03);
`ifdef TIMER_CTRL_AUTORELOAD_EN
    chk("reload_load", 32'(state_o), 32'd1);
    tick;
    chk("reload_run", 32'(state_o), 32'd2);
    chk("reload_en", 32'(core_en_o), 32'd1);
`else
    chk("exp_hold", 32'(state_o), 32'd4);
    tick;
    chk("exp_hold2", 32'(state_o), 32'd4);
    chk("exp_alarm_quiet", 32'(alarm_o), 32'd0);
    pulse(0);
    chk("restart_load", 32'(state_o), 32'd1);
    tick;
    chk("restart_run", 32'(state_o), 32'd2);
`endif

    // clear and start together while alarm sounds
    pulse(4);
    chk("exp2_alarm", 32'(alarm_o), 32'd1);
    repeat (3) tick;
    start_i = 1'b1; clear_i = 1'b1;
    tick;
    start_i = 1'b0; clear_i = 1'b0;
    chk("sc_state", 32'(state_o), 32'd0);
    chk("sc_alarm", 32'(alarm_o), 32'd0);
    chk("sc_crst", 32'(core_rst_o), 32'd1);
    chk("sc_min", 32'(min_o), 32'h01);
    chk("sc_sec", 32'(sec_o), 32'h03);

    // inc ignored in RUN, clear from RUN
    pulse(0);
    tick;
    pulse(3);
    pulse(2);
    chk("run_inc_sec", 32'(sec_o), 32'h03);
    chk("run_inc_min", 32'(min_o), 32'h01);
    pulse(1);
    chk("run_clear", 32'(state_o), 32'd0);
    chk("run_clear_crst", 32'(core_rst_o), 32'd1);

    // BCD wrap sweep
    pulse(1);
    chk("clr_min", 32'(min_o), 32'h00);
    chk("clr_sec", 32'(sec_o), 32'h00);
    pulse(2);
    for (int i = 1; i <= 60; i++) begin
      pulse(3);
      if (i == 9)  chk("sec_09", 32'(sec_o), 32'h09);
      if (i == 10) chk("sec_10", 32'(sec_o), 32'h10);
      if (i == 59) chk("sec_59", 32'(sec_o), 32'h59);
      if (i == 60) chk("sec_wrap", 32'(sec_o), 32'h00);
    end
    chk("sweep_min", 32'(min_o), 32'h01);
    repeat (58) pulse(2);
    chk("min_59", 32'(min_o), 32'h59);
    pulse(2);
    chk("min_wrap", 32'(min_o), 32'h00);
    min_inc_i = 1'b1; sec_inc_i = 1'b1;
    tick;
    min_inc_i = 1'b0; sec_inc_i = 1'b0;
    chk("both_min", 32'(min_o), 32'h01);
    chk("both_sec", 32'(sec_o), 32'h01);

    // async reset mid-RUN
    pulse(0);
    tick;
    chk("pre_rst_run", 32'(state_o), 32'd2);
    #3 rst = 1'b0;
    #1 chk_rst("async_rst");
    tick;
    chk("rst_hold", 32'(state_o), 32'd0);
    rst = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
